lap_recall: RTL

LAP_RECALL -- requirements
Module: lap_recall

---
 rtl/lap_recall_if.sv | 31 +++
 rtl/lap_recall.sv | 94 +++++++++
 2 files changed

// File: rtl/lap_recall_if.sv
// Bundles the lap-timer control pulses, live digits and recall display outputs.
// The master side drives the pulses and digits; the slave side is the lap_recall core.
interface lap_recall_if;
  logic       lap;
  logic       view;
  logic       exit;
  logic [3:0] din0;
  logic [3:0] din1;
  logic [3:0] din2;
  logic [3:0] din3;
  logic [3:0] dout0;
  logic [3:0] dout1;
  logic [3:0] dout2;
  logic [3:0] dout3;
  logic [2:0] idx;
  logic [3:0] count;
  logic       showing;
  logic       full;
  logic       empty;
  logic       ovf;

  modport master (
    output lap, view, exit, din0, din1, din2, din3,
    input  dout0, dout1, dout2, dout3, idx, count, showing, full, empty, ovf
  );

  modport slave (
    input  lap, view, exit, din0, din1, din2, din3,
    output dout0, dout1, dout2, dout3, idx, count, showing, full, empty, ovf
  );
endinterface

// File: rtl/lap_recall.sv
// Lap memory for a BCD stopwatch: captures up to DEPTH lap times in order and
// lets the user step through them (oldest first, wrapping) in recall mode.
module lap_recall #(
  parameter int DEPTH = 8
) (
  input logic         clk,
  input logic         clr,
  lap_recall_if.slave bus
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] rec [DEPTH];
  logic [3:0]  cnt;
  logic        ovf_r;
  logic [15:0] dout_r;
  logic [15:0] dout_nxt;
  logic [2:0]  idx_r;
  logic [2:0]  idx_nxt;
  logic        full_w;

  assign full_w = (cnt == DEPTH_C);

  // Display FSM: view/exit decisions use pre-edge count and record contents.
  always_comb begin
    state_nxt = state;
    dout_nxt  = dout_r;
    idx_nxt   = idx_r;
    case (state)
      IDLE: begin
        if (bus.view && (cnt != 4'd0)) begin
          state_nxt = SHOW;
          idx_nxt   = 3'd0;
          dout_nxt  = rec[0];
        end
      end
      SHOW: begin
        if (bus.exit) begin
          state_nxt = IDLE;
          idx_nxt   = 3'd0;
          dout_nxt  = 16'd0;
        end else if (bus.view) begin
          idx_nxt  = ({1'b0, idx_r} == (cnt - 4'd1)) ? 3'd0 : (idx_r + 3'd1);
          dout_nxt = rec[idx_nxt];
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = 3'd0;
        dout_nxt  = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      dout_r <= 16'd0;
      idx_r  <= 3'd0;
      cnt    <= 4'd0;
      ovf_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      dout_r <= dout_nxt;
      idx_r  <= idx_nxt;
      if (bus.lap) begin
        if (!full_w) cnt   <= cnt + 4'd1;
        else         ovf_r <= 1'b1;
      end
    end
  end

  // Record storage carries no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (bus.lap && !full_w)
      rec[cnt[2:0]] <= {bus.din3, bus.din2, bus.din1, bus.din0};
  end

  assign bus.dout0   = dout_r[3:0];
  assign bus.dout1   = dout_r[7:4];
  assign bus.dout2   = dout_r[11:8];
  assign bus.dout3   = dout_r[15:12];
  assign bus.idx     = idx_r;
  assign bus.count   = cnt;
  assign bus.showing = (state == SHOW);
  assign bus.full    = full_w;
  assign bus.empty   = (cnt == 4'd0);
  assign bus.ovf     = ovf_r;

endmodule
